// File: rtl/selftest_if.sv
// selftest_if: test-control, expected-value programming and core debug-port signals of the self-test sequencer
interface selftest_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS = 4
);
  localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1;
  logic start;
  logic exp_we;
  logic [IW-1:0] exp_idx;
  logic [REG_ADDR_WIDTH-1:0] exp_reg;
  logic [DATA_WIDTH-1:0] exp_val;
  logic exp_en;
  logic cpu_rst;
  logic [REG_ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_data;
  logic busy;
  logic done;
  logic pass;
  logic [NUM_CHECKS-1:0] fail_mask;
  modport master (
    output start, exp_we, exp_idx, exp_reg, exp_val, exp_en, dbg_data,
    input cpu_rst, dbg_addr, busy, done, pass, fail_mask
  );
  modport slave (
    input start, exp_we, exp_idx, exp_reg, exp_val, exp_en, dbg_data,
    output cpu_rst, dbg_addr, busy, done, pass, fail_mask
  );
endinterface

// File: rtl/selftest_controller.sv
// selftest_controller: resets and runs the core under test, then checks selected register-file entries against programmed values
module selftest_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS = 4,
  parameter int RESET_CYCLES = 2,
  parameter int RUN_CYCLES = 10
) (
  input logic clk,
  input logic rst,
  selftest_if.slave bus
);
  localparam int IW = NUM_CHECKS > 1 ? $clog2(NUM_CHECKS) : 1;
  localparam int CMAX = RESET_CYCLES > RUN_CYCLES ? RESET_CYCLES : RUN_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, HOLD_RST, RUN, CHK_ADDR, CHK_CMP, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [NUM_CHECKS-1:0] en;
  logic [NUM_CHECKS-1:0] nm;
  logic [REG_ADDR_WIDTH-1:0] regs [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] vals [NUM_CHECKS];
  logic wr, last, step, fin;
  assign wr = bus.exp_we && (state == IDLE || state == DONE) && int'(bus.exp_idx) < NUM_CHECKS;
  assign last = idx == IW'(NUM_CHECKS - 1);
  assign step = state == CHK_CMP || (state == CHK_ADDR && !en[idx]);
  assign fin = step && last;
  always_comb begin
    nm = bus.fail_mask;
    nm[idx] = bus.fail_mask[idx] | (state == CHK_CMP && bus.dbg_data != vals[idx]);
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      regs[bus.exp_idx] <= bus.exp_reg;
      vals[bus.exp_idx] <= bus.exp_val;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      en <= '0;
      bus.cpu_rst <= 1'b1;
      bus.dbg_addr <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.pass <= 1'b0;
      bus.fail_mask <= '0;
    end else begin
      if (wr) en[bus.exp_idx] <= bus.exp_en;
      case (state)
        IDLE, DONE: if (bus.start) begin
          state <= HOLD_RST;
          cnt <= '0;
          bus.cpu_rst <= 1'b1;
          bus.busy <= 1'b1;
          bus.done <= 1'b0;
          bus.pass <= 1'b0;
          bus.fail_mask <= '0;
        end
        HOLD_RST: if (cnt == CW'(RESET_CYCLES - 1)) begin
          state <= RUN;
          cnt <= '0;
          bus.cpu_rst <= 1'b0;
        end else cnt <= cnt + 1'b1;
        RUN: if (cnt == CW'(RUN_CYCLES - 1)) begin
          state <= CHK_ADDR;
          idx <= '0;
          bus.cpu_rst <= 1'b1;
        end else cnt <= cnt + 1'b1;
        CHK_ADDR: if (en[idx]) begin
          bus.dbg_addr <= regs[idx];
          state <= CHK_CMP;
        end
        CHK_CMP: bus.fail_mask <= nm;
        default: state <= IDLE;
      endcase
      // skipped slots and completed compares share one advance path
      if (step) begin
        state <= fin ? DONE : CHK_ADDR;
        idx <= idx + 1'b1;
        if (fin) begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.pass <= ~|nm;
        end
      end
    end
  end
endmodule

// File: tb/tb_selftest_controller.sv
// tb_selftest_controller: table-driven vectors plus hand sequences for abort, ignored start/write and same-cycle programming
module tb_selftest_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int passed = 0;
  logic [31:0] rf [32];
  selftest_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_CHECKS(4)) bus ();
  selftest_controller #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_CHECKS(4),
    .RESET_CYCLES(2), .RUN_CYCLES(10)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  assign bus.dbg_data = rf[bus.dbg_addr];
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] en;
    logic [31:0] r9;
    logic [31:0] r11;
    int lat;
    logic pass;
    logic [3:0] mask;
    logic [14:0] seq;
  } vec_t;
  vec_t v [6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic wslot(input logic [1:0] i, input logic [4:0] r, input logic [31:0] val, input logic e);
    bus.exp_we = 1'b1;
    bus.exp_idx = i;
    bus.exp_reg = r;
    bus.exp_val = val;
    bus.exp_en = e;
    @(negedge clk);
    bus.exp_we = 1'b0;
  endtask
  task automatic prog(input logic [3:0] e);
    wslot(2'd0, 5'd8, 32'd5, e[0]);
    wslot(2'd1, 5'd9, 32'd10, e[1]);
    wslot(2'd2, 5'd10, 32'd15, e[2]);
    wslot(2'd3, 5'd11, 32'd20, e[3]);
  endtask
  task automatic run(input int start_at, input int wr_at, input logic [31:0] wval,
                     output int lat, output int low, output logic [14:0] seq);
    int n;
    logic [4:0] prev;
    n = 0;
    low = 0;
    seq = '0;
    prev = bus.dbg_addr;
    bus.exp_idx = 2'd1;
    bus.exp_reg = 5'd9;
    bus.exp_val = wval;
    bus.exp_en = 1'b1;
    bus.start = 1'b1;
    bus.exp_we = (wr_at == 0);
    do begin
      @(negedge clk);
      n++;
      if (!bus.cpu_rst) low++;
      if (bus.dbg_addr != prev) begin
        seq = {seq[9:0], bus.dbg_addr};
        prev = bus.dbg_addr;
      end
      bus.start = (n == start_at);
      bus.exp_we = (n == wr_at);
    end while (!bus.done && n < 100);
    bus.start = 1'b0;
    bus.exp_we = 1'b0;
    lat = n;
  endtask
  initial begin
    int lat, low;
    logic [14:0] seq;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
    rf[8] = 32'd5;
    rf[10] = 32'd15;
    bus.start = 1'b0;
    bus.exp_we = 1'b0;
    bus.exp_idx = '0;
    bus.exp_reg = '0;
    bus.exp_val = '0;
    bus.exp_en = 1'b0;
    v[0] = '{4'b0111, 32'd10, 32'd20, 20, 1'b1, 4'b0000, {5'd8, 5'd9, 5'd10}};
    v[1] = '{4'b0111, 32'd11, 32'd20, 20, 1'b0, 4'b0010, {5'd8, 5'd9, 5'd10}};
    v[2] = '{4'b0000, 32'd10, 32'd20, 17, 1'b1, 4'b0000, 15'd0};
    v[3] = '{4'b1111, 32'd10, 32'd20, 21, 1'b1, 4'b0000, {5'd9, 5'd10, 5'd11}};
    v[4] = '{4'b1010, 32'd11, 32'd21, 19, 1'b0, 4'b1010, {5'd0, 5'd9, 5'd11}};
    v[5] = '{4'b0010, 32'h8000000A, 32'd20, 18, 1'b0, 4'b0010, {5'd0, 5'd0, 5'd9}};
    repeat (2) @(negedge clk);
    chk("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_pass", 64'(bus.pass), 64'd0);
    chk("rst_mask", 64'(bus.fail_mask), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rf[9] = v[k].r9;
      rf[11] = v[k].r11;
      prog(v[k].en);
      run(-1, -1, 32'd0, lat, low, seq);
      chk($sformatf("v%0d_latency", k), 64'(lat), 64'(v[k].lat));
      chk($sformatf("v%0d_pass", k), 64'(bus.pass), 64'(v[k].pass));
      chk($sformatf("v%0d_mask", k), 64'(bus.fail_mask), 64'(v[k].mask));
      chk($sformatf("v%0d_run_low", k), 64'(low), 64'd10);
      chk($sformatf("v%0d_addr_seq", k), 64'(seq), 64'(v[k].seq));
      chk($sformatf("v%0d_busy", k), 64'(bus.busy), 64'd0);
    end
    repeat (3) @(negedge clk);
    chk("done_hold", 64'(bus.done), 64'd1);
    chk("done_hold_mask", 64'(bus.fail_mask), 64'b0010);
    rf[9] = 32'd10;
    rf[11] = 32'd20;
    prog(4'b0111);
    run(6, 14, 32'd99, lat, low, seq);
    chk("ign_latency", 64'(lat), 64'd20);
    chk("ign_pass", 64'(bus.pass), 64'd1);
    chk("ign_run_low", 64'(low), 64'd10);
    run(-1, -1, 32'd0, lat, low, seq);
    chk("ign_slot_kept", 64'(bus.pass), 64'd1);
    chk("ign_slot_kept_mask", 64'(bus.fail_mask), 64'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_in_run", 64'(bus.cpu_rst), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    run(-1, -1, 32'd0, lat, low, seq);
    chk("abort_rerun_latency", 64'(lat), 64'd17);
    chk("abort_rerun_pass", 64'(bus.pass), 64'd1);
    chk("abort_rerun_mask", 64'(bus.fail_mask), 64'd0);
    run(-1, 0, 32'd11, lat, low, seq);
    chk("same_cycle_wr_latency", 64'(lat), 64'd18);
    chk("same_cycle_wr_pass", 64'(bus.pass), 64'd0);
    chk("same_cycle_wr_mask", 64'(bus.fail_mask), 64'b0010);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/selftest_controller.md
Name: selftest_controller

Overview:
Synthesizable on-chip self-test sequencer for the single-cycle MIPS core. It holds the core in reset, runs it for a programmed number of cycles, then reads selected register-file entries through a debug read port and compares each against an expected value. It reports pass/fail with a per-check failure mask. Expected values are loaded at runtime, and the check count, widths and durations are parametrised.

Parameters:
DATA_WIDTH, 32, register data width
REG_ADDR_WIDTH, 5, register-file address width
NUM_CHECKS, 4, number of expected-value slots (1..16)
RESET_CYCLES, 2, cycles cpu_rst is held high after start (>=1)
RUN_CYCLES, 10, cycles the core runs with cpu_rst low (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse; begins a test run from IDLE or DONE
exp_we  in  1  write one expected-value slot
exp_idx  in  clog2(NUM_CHECKS) (min 1)  slot index for exp_we
exp_reg  in  REG_ADDR_WIDTH  register number to check
exp_val  in  DATA_WIDTH  expected register contents
exp_en  in  1  slot valid bit written with exp_we (0 = slot skipped)
cpu_rst  out  1  reset to the core under test
dbg_addr  out  REG_ADDR_WIDTH  register-file debug read address (registered)
dbg_data  in  DATA_WIDTH  register-file debug read data
busy  out  1  high in HOLD_RST, RUN, CHK_ADDR and CHK_CMP
done  out  1  high in DONE
pass  out  1  valid when done; 1 when fail_mask == 0
fail_mask  out  NUM_CHECKS  bit i set when enabled slot i mismatched

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, cpu_rst=1, dbg_addr=0, busy=0, done=0, pass=0, fail_mask=0. All slot valid bits are cleared; slot reg/val contents are don't-care.
- In IDLE the core is held in reset (cpu_rst=1).
- Slot writes: exp_we writes {exp_en, exp_reg, exp_val} into slot exp_idx in IDLE or DONE. Writes are ignored while busy. An out-of-range exp_idx is ignored.
- FSM:
  - IDLE/DONE + start -> HOLD_RST on the next edge. fail_mask, pass and done are cleared on that edge.
  - HOLD_RST: cpu_rst=1 for exactly RESET_CYCLES cycles, then -> RUN.
  - RUN: cpu_rst=0 for exactly RUN_CYCLES cycles (counter from 0), then -> CHK_ADDR with slot index i=0. cpu_rst returns to 1 on entry to CHK_ADDR, which freezes the core.
  - CHK_ADDR: if slot i is valid, drive dbg_addr=exp_reg[i] and -> CHK_CMP. If slot i is invalid, advance i in the same cycle (one cycle per skipped slot).
  - CHK_CMP: sample dbg_data, which must be stable one cycle after dbg_addr changes. fail_mask[i] <= (dbg_data != exp_val[i]). Then advance i.
  - After the last slot -> DONE. pass <= (final fail_mask == 0), done=1.
  - DONE holds its outputs until start or rst.
- Latency with all slots valid: start to done = 1 + RESET_CYCLES + RUN_CYCLES + 2*NUM_CHECKS cycles.
- Boundary rules:
  - start while busy: ignored.
  - start and exp_we in the same cycle in IDLE: the write lands and the run uses the new value.
  - All slots invalid: DONE with pass=1, fail_mask=0.
  - rst mid-run: IDLE with cpu_rst=1 on that edge; valid bits cleared.
  - Counters must not wrap: run counter width is clog2(RUN_CYCLES+1).
  - Comparison is full DATA_WIDTH equality with no masking.

Test Plan:
- Reset: drive rst 2 cycles -> cpu_rst=1, busy=0, done=0, pass=0, fail_mask=0.
- Program with slots 0..2 = reg 8/5, reg 9/10, reg 10/15, slot 3 disabled. Pulse start with the core model holding those values -> done exactly 1+2+10+2*3+1 cycles later (skipped slot takes 1 cycle); pass=1, fail_mask=4'b0000; cpu_rst low for exactly 10 cycles.
- Same setup with reg 9 = 11 in the model -> pass=0, fail_mask=4'b0010; dbg_addr sequence observed is 8, 9, 10.
- No slots enabled, pulse start -> done after 1+2+10+4 cycles, pass=1.
- Pulse start again during RUN, and exp_we during CHK_CMP -> both ignored; run length and slot contents unchanged.
- Assert rst during RUN cycle 5 -> next edge IDLE, cpu_rst=1. Restart without reprogramming -> pass=1 with fail_mask=0 (all slots invalid).
